sensor_packet_ctrl: RTL and testbench

Clock-domain controller that sequences consumption of 16-byte sensor packets already captured by the SPI receive front end. It validates each captured packet (header, optional XOR checksum) and decodes Roll/Pitch/Yaw/Gyro/Flags into signed fields. Decoded fields go to the MCU-facing logic through a one-entry valid/ready output register. It also runs a link watchdog and saturating statistics counters.

---
 rtl/sensor_pkt_pkg.sv | 48 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/sensor_packet_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sensor_packet_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkt_pkg.sv
// Shared definitions for the sensor packet controller: packet geometry, byte offsets,
// controller state encoding and the decoded-field record.
package sensor_pkt_pkg;

    localparam int unsigned PACKET_SIZE = 16;
    localparam int unsigned PACKET_W    = PACKET_SIZE * 8;
    localparam logic [7:0]  HEADER_BYTE = 8'hAA;

    // Byte offsets within a packet (byte 0 is the header)
    localparam int unsigned HDR       = 0;
    localparam int unsigned ROLL_MSB  = 1;
    localparam int unsigned ROLL_LSB  = 2;
    localparam int unsigned PITCH_MSB = 3;
    localparam int unsigned PITCH_LSB = 4;
    localparam int unsigned YAW_MSB   = 5;
    localparam int unsigned YAW_LSB   = 6;
    localparam int unsigned GX_MSB    = 7;
    localparam int unsigned GX_LSB    = 8;
    localparam int unsigned GY_MSB    = 9;
    localparam int unsigned GY_LSB    = 10;
    localparam int unsigned GZ_MSB    = 11;
    localparam int unsigned GZ_LSB    = 12;
    localparam int unsigned FLAGS     = 13;
    localparam int unsigned CHK       = 15;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT
    } ctrl_state_t;

    typedef struct packed {
        logic signed [15:0] roll;
        logic signed [15:0] pitch;
        logic signed [15:0] yaw;
        logic signed [15:0] gyro_x;
        logic signed [15:0] gyro_y;
        logic signed [15:0] gyro_z;
        logic [7:0]         flags;
    } sensor_fields_t;

    // Packets travel flattened with byte 0 in the most significant position.
    function automatic logic [7:0] pkt_byte(input logic [PACKET_W-1:0] pkt,
                                            input int unsigned idx);
        return pkt[(PACKET_SIZE - 1 - idx) * 8 +: 8];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports: clk, reset (sync, active-high), inc (count enable), count (current value).
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sensor_packet_ctrl.sv
// Sensor packet controller: latches a captured 16-byte packet, validates header and optional
// XOR checksum, decodes signed attitude/gyro fields into a one-entry valid/ready output
// register, runs a link watchdog and keeps saturating statistics.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   pkt_strobe, pkt_bytes new packet pulse; bytes flattened, byte 0 in bits [127:120]
//   out_valid, out_ready  output handshake
//   roll..gyro_z, flags   decoded fields of the presented packet
//   link_up, link_lost    link status and one-cycle loss pulse
//   *_count               saturating good/bad/drop/overrun statistics
module sensor_packet_ctrl #(
    parameter logic [7:0]  HEADER_BYTE    = sensor_pkt_pkg::HEADER_BYTE,
    parameter bit          CHECK_XOR      = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pkt_strobe,
    input  logic [127:0]       pkt_bytes,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] roll,
    output logic signed [15:0] pitch,
    output logic signed [15:0] yaw,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic [7:0]         flags,
    output logic               link_up,
    output logic               link_lost,
    output logic [CNT_W-1:0]   good_count,
    output logic [CNT_W-1:0]   bad_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CNT_W-1:0]   overrun_count
);

    import sensor_pkt_pkg::*;

    localparam int unsigned WD_W    = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t          state_q, state_d;
    logic [PACKET_W-1:0]  shadow_q;
    logic                 good_q, good_d;
    sensor_fields_t       dec_q, dec_d, dec_c;
    sensor_fields_t       out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 link_up_q, link_up_d;
    logic                 link_lost_q, link_lost_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [7:0]           xor_c;
    logic                 commit_good, commit_bad, accept, timeout, overrun, drop;

    // Field decode and checksum straight off the shadow copy
    always_comb begin
        xor_c = '0;
        for (int unsigned i = 0; i < PACKET_SIZE - 1; i++) begin
            xor_c = xor_c ^ pkt_byte(shadow_q, i);
        end
        dec_c.roll   = {pkt_byte(shadow_q, ROLL_MSB),  pkt_byte(shadow_q, ROLL_LSB)};
        dec_c.pitch  = {pkt_byte(shadow_q, PITCH_MSB), pkt_byte(shadow_q, PITCH_LSB)};
        dec_c.yaw    = {pkt_byte(shadow_q, YAW_MSB),   pkt_byte(shadow_q, YAW_LSB)};
        dec_c.gyro_x = {pkt_byte(shadow_q, GX_MSB),    pkt_byte(shadow_q, GX_LSB)};
        dec_c.gyro_y = {pkt_byte(shadow_q, GY_MSB),    pkt_byte(shadow_q, GY_LSB)};
        dec_c.gyro_z = {pkt_byte(shadow_q, GZ_MSB),    pkt_byte(shadow_q, GZ_LSB)};
        dec_c.flags  = pkt_byte(shadow_q, FLAGS);
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        dec_d   = dec_q;
        unique case (state_q)
            IDLE: begin
                if (pkt_strobe) state_d = CHECK;
            end
            CHECK: begin
                good_d  = (pkt_byte(shadow_q, HDR) == HEADER_BYTE) &&
                          (!CHECK_XOR || (pkt_byte(shadow_q, CHK) == xor_c));
                dec_d   = dec_c;
                state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign commit_good = (state_q == COMMIT) && good_q;
    assign commit_bad  = (state_q == COMMIT) && !good_q;
    assign accept      = out_valid_q && out_ready;
    // Only an un-consumed entry being overwritten counts as a drop
    assign drop        = commit_good && out_valid_q && !out_ready;
    assign overrun     = pkt_strobe && (state_q != IDLE);
    assign timeout     = link_up_q && (wd_q == WD_LAST);

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (commit_good) begin
            out_d       = dec_q;
            out_valid_d = 1'b1;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // Watchdog: a good commit beats a coincident timeout
    always_comb begin
        link_up_d   = link_up_q;
        link_lost_d = 1'b0;
        wd_d        = wd_q;
        if (commit_good) begin
            link_up_d = 1'b1;
            wd_d      = '0;
        end else if (timeout) begin
            link_up_d   = 1'b0;
            link_lost_d = 1'b1;
            wd_d        = '0;
        end else if (link_up_q) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            good_q      <= 1'b0;
            dec_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            link_up_q   <= 1'b0;
            link_lost_q <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            dec_q       <= dec_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            link_up_q   <= link_up_d;
            link_lost_q <= link_lost_d;
            wd_q        <= wd_d;
            if ((state_q == IDLE) && pkt_strobe) shadow_q <= pkt_bytes;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk(clk), .reset(reset), .inc(commit_good), .count(good_count)
    );
    sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk(clk), .reset(reset), .inc(commit_bad), .count(bad_count)
    );
    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk(clk), .reset(reset), .inc(drop), .count(drop_count)
    );
    sat_counter #(.CNT_W(CNT_W)) u_overrun_cnt (
        .clk(clk), .reset(reset), .inc(overrun), .count(overrun_count)
    );

    assign out_valid = out_valid_q;
    assign roll      = out_q.roll;
    assign pitch     = out_q.pitch;
    assign yaw       = out_q.yaw;
    assign gyro_x    = out_q.gyro_x;
    assign gyro_y    = out_q.gyro_y;
    assign gyro_z    = out_q.gyro_z;
    assign flags     = out_q.flags;
    assign link_up   = link_up_q;
    assign link_lost = link_lost_q;

endmodule

// File: tb/tb_sensor_packet_ctrl.sv
// Directed bench: table of packets with hand-decoded fields, then hand-written sequences for
// backpressure, accept+commit, overrun, checksum, saturation, watchdog and mid-packet reset.
module tb_sensor_packet_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         strobe, strobe_x, ready;
    logic [127:0] bytes_in;

    logic        valid, link_up, link_lost;
    logic [15:0] roll, pitch, yaw, gx, gy, gz;
    logic [7:0]  flags;
    logic [15:0] good_c, bad_c, drop_c, ovr_c;

    logic        x_valid, x_link_up, x_link_lost;
    logic [15:0] x_roll, x_pitch, x_yaw, x_gx, x_gy, x_gz;
    logic [7:0]  x_flags;
    logic [1:0]  x_good_c, x_bad_c, x_drop_c, x_ovr_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sensor_packet_ctrl #(
        .HEADER_BYTE(8'hAA), .CHECK_XOR(1'b0), .TIMEOUT_CYCLES(50), .CNT_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .pkt_strobe(strobe), .pkt_bytes(bytes_in),
        .out_valid(valid), .out_ready(ready),
        .roll(roll), .pitch(pitch), .yaw(yaw),
        .gyro_x(gx), .gyro_y(gy), .gyro_z(gz), .flags(flags),
        .link_up(link_up), .link_lost(link_lost),
        .good_count(good_c), .bad_count(bad_c), .drop_count(drop_c), .overrun_count(ovr_c)
    );

    // Checksum-enabled instance with narrow counters to reach saturation quickly
    sensor_packet_ctrl #(
        .HEADER_BYTE(8'hAA), .CHECK_XOR(1'b1), .TIMEOUT_CYCLES(50), .CNT_W(2)
    ) u_dut_x (
        .clk(clk), .reset(reset), .pkt_strobe(strobe_x), .pkt_bytes(bytes_in),
        .out_valid(x_valid), .out_ready(ready),
        .roll(x_roll), .pitch(x_pitch), .yaw(x_yaw),
        .gyro_x(x_gx), .gyro_y(x_gy), .gyro_z(x_gz), .flags(x_flags),
        .link_up(x_link_up), .link_lost(x_link_lost),
        .good_count(x_good_c), .bad_count(x_bad_c), .drop_count(x_drop_c),
        .overrun_count(x_ovr_c)
    );

    typedef struct {
        logic [127:0] bytes;
        logic         good;
        logic [15:0]  roll, pitch, yaw, gx, gy, gz;
        logic [7:0]   flags;
    } vec_t;

    vec_t vecs[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_roll(input logic [15:0] r);
        return {8'hAA, r, 104'h0};
    endfunction

    // Drive one packet to the selected instance and advance to the cycle its commit is visible.
    task automatic send(input logic [127:0] b, input bit to_x);
        bytes_in = b;
        if (to_x) strobe_x = 1'b1; else strobe = 1'b1;
        step();
        strobe = 1'b0;
        strobe_x = 1'b0;
        step();
        step();
    endtask

    int          exp_good, exp_bad;
    logic        exp_link;
    logic [15:0] e_roll, e_pitch, e_yaw, e_gx, e_gy, e_gz;
    logic [7:0]  e_flags;
    int          lost_seen;

    initial begin
        vecs[0] = '{bytes: 128'hAA0064FF9C012C07D0F8300000050000, good: 1'b1,
                    roll: 16'd100, pitch: -16'sd100, yaw: 16'd300,
                    gx: 16'd2000, gy: -16'sd2000, gz: 16'd0, flags: 8'h05};
        vecs[1] = '{bytes: 128'h550064FF9C012C07D0F8300000050000, good: 1'b0,
                    roll: 16'd0, pitch: 16'd0, yaw: 16'd0,
                    gx: 16'd0, gy: 16'd0, gz: 16'd0, flags: 8'h00};
        vecs[2] = '{bytes: 128'hAA80007FFF0001FFFF1234ABCDA50000, good: 1'b1,
                    roll: -16'sd32768, pitch: 16'd32767, yaw: 16'd1,
                    gx: -16'sd1, gy: 16'd4660, gz: -16'sd21555, flags: 8'hA5};

        reset = 1'b1; strobe = 1'b0; strobe_x = 1'b0; ready = 1'b1; bytes_in = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset out_valid", 32'(valid), 0);
        chk("reset roll", 32'(roll), 0);
        chk("reset flags", 32'(flags), 0);
        chk("reset link_up", 32'(link_up), 0);
        chk("reset link_lost", 32'(link_lost), 0);
        chk("reset counts", {good_c, bad_c | drop_c | ovr_c}, 0);

        // Table: decode, header check, N+3 latency, acceptance with out_ready=1
        exp_good = 0; exp_bad = 0; exp_link = 1'b0;
        e_roll = '0; e_pitch = '0; e_yaw = '0; e_gx = '0; e_gy = '0; e_gz = '0; e_flags = '0;
        for (int i = 0; i < 3; i++) begin
            bytes_in = vecs[i].bytes;
            strobe = 1'b1;
            step();
            strobe = 1'b0;
            step();
            chk("latency valid low at N+2", 32'(valid), 0);
            step();
            if (vecs[i].good) begin
                exp_good++; exp_link = 1'b1;
                e_roll = vecs[i].roll; e_pitch = vecs[i].pitch; e_yaw = vecs[i].yaw;
                e_gx = vecs[i].gx; e_gy = vecs[i].gy; e_gz = vecs[i].gz; e_flags = vecs[i].flags;
            end else begin
                exp_bad++;
            end
            chk("vec out_valid", 32'(valid), 32'(vecs[i].good));
            chk("vec roll", 32'(roll), 32'(e_roll));
            chk("vec pitch", 32'(pitch), 32'(e_pitch));
            chk("vec yaw", 32'(yaw), 32'(e_yaw));
            chk("vec gyro_x", 32'(gx), 32'(e_gx));
            chk("vec gyro_y", 32'(gy), 32'(e_gy));
            chk("vec gyro_z", 32'(gz), 32'(e_gz));
            chk("vec flags", 32'(flags), 32'(e_flags));
            chk("vec good_count", 32'(good_c), 32'(exp_good));
            chk("vec bad_count", 32'(bad_c), 32'(exp_bad));
            chk("vec link_up", 32'(link_up), 32'(exp_link));
            step();
            chk("vec valid after accept", 32'(valid), 0);
        end

        // Backpressure: second good packet overwrites the unconsumed first
        ready = 1'b0;
        send(mk_roll(16'd1), 1'b0);
        chk("bp first valid", 32'(valid), 1);
        chk("bp first roll", 32'(roll), 1);
        step();
        chk("bp hold valid", 32'(valid), 1);
        chk("bp hold roll", 32'(roll), 1);
        send(mk_roll(16'd2), 1'b0);
        chk("bp second roll", 32'(roll), 2);
        chk("bp drop_count", 32'(drop_c), 1);
        chk("bp good_count", 32'(good_c), 4);
        ready = 1'b1;
        step();
        chk("bp valid falls after accept", 32'(valid), 0);

        // Accept and commit on the same edge: new packet wins, no drop
        ready = 1'b0;
        send(mk_roll(16'd3), 1'b0);
        chk("ac first roll", 32'(roll), 3);
        bytes_in = mk_roll(16'd4);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        ready = 1'b1;
        step();
        chk("ac valid stays", 32'(valid), 1);
        chk("ac roll new", 32'(roll), 4);
        chk("ac no drop", 32'(drop_c), 1);
        step();
        chk("ac valid falls", 32'(valid), 0);

        // Overrun: strobe held into CHECK with different bytes
        bytes_in = mk_roll(16'd5);
        strobe = 1'b1;
        step();
        bytes_in = mk_roll(16'd6);
        step();
        strobe = 1'b0;
        step();
        chk("ovr valid", 32'(valid), 1);
        chk("ovr roll first", 32'(roll), 5);
        chk("ovr count", 32'(ovr_c), 1);
        chk("ovr good_count", 32'(good_c), 7);
        step();

        // Checksum instance: correct XOR accepted, flipped byte 15 rejected, then saturation
        send(128'hAA0102030405060708090A0B0C0D0EA5, 1'b1);
        chk("xor good valid", 32'(x_valid), 1);
        chk("xor good fields", {x_roll, x_pitch}, 32'h0102_0304);
        chk("xor good yaw/gx", {x_yaw, x_gx}, 32'h0506_0708);
        chk("xor good gy/gz", {x_gy, x_gz}, 32'h090A_0B0C);
        chk("xor good flags", 32'(x_flags), 32'h0D);
        chk("xor link", {x_link_up, x_link_lost}, 32'b10);
        chk("xor good_count", 32'(x_good_c), 1);
        step();
        send(128'hAA0102030405060708090A0B0C0D0E5A, 1'b1);
        chk("xor bad valid", 32'(x_valid), 0);
        chk("xor bad roll kept", 32'(x_roll), 32'h0102);
        chk("xor bad_count", 32'(x_bad_c), 1);
        chk("xor good_count held", 32'(x_good_c), 1);
        step();
        for (int k = 0; k < 2; k++) begin
            send(128'hAA0102030405060708090A0B0C0D0E5A, 1'b1);
            step();
        end
        chk("sat reaches max", 32'(x_bad_c), 3);
        send(128'hAA0102030405060708090A0B0C0D0E5A, 1'b1);
        chk("sat no wrap", 32'(x_bad_c), 3);
        chk("xor no drop/overrun", {x_drop_c, x_ovr_c}, 0);
        step();

        // Watchdog: 50 cycles without a good packet drops the link
        send(mk_roll(16'd7), 1'b0);
        chk("wd link up", 32'(link_up), 1);
        lost_seen = 0;
        for (int k = 0; k < 49; k++) begin
            step();
            if (link_lost) lost_seen++;
        end
        chk("wd still up at 49", 32'(link_up), 1);
        chk("wd no early pulse", 32'(lost_seen), 0);
        step();
        chk("wd link down at 50", 32'(link_up), 0);
        chk("wd lost pulse", 32'(link_lost), 1);
        step();
        chk("wd lost one cycle", 32'(link_lost), 0);
        repeat (5) step();
        chk("wd stays down", 32'(link_up), 0);
        send(mk_roll(16'd8), 1'b0);
        chk("wd restored", 32'(link_up), 1);

        // Good commit coincides with the timeout edge: link stays up, no pulse
        repeat (47) step();
        send(mk_roll(16'd9), 1'b0);
        chk("wd tie link up", 32'(link_up), 1);
        chk("wd tie no pulse", 32'(link_lost), 0);
        repeat (49) step();
        chk("wd tie counter cleared", 32'(link_up), 1);

        // Reset while a packet is in flight
        bytes_in = mk_roll(16'd10);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("mid reset valid", 32'(valid), 0);
        chk("mid reset roll", 32'(roll), 0);
        chk("mid reset link", 32'(link_up), 0);
        chk("mid reset counts", {good_c, bad_c | drop_c | ovr_c}, 0);
        send(mk_roll(16'd11), 1'b0);
        chk("post reset valid", 32'(valid), 1);
        chk("post reset roll", 32'(roll), 11);
        chk("post reset good_count", 32'(good_c), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
